// File: rtl/prio_arbiter_rr_pkg.sv
// Shared constants, lane enumeration and command classification for the
// two-lane priority/round-robin dispatch arbiter.
package prio_pkg;

  localparam int CMD_W_DEF = 4;
  localparam int LANE1_MAX = 3;

  typedef enum logic [1:0] {
    LANE_NONE = 2'd0,
    LANE_ALU1 = 2'd1,
    LANE_ALU2 = 2'd2
  } lane_e;

  // Zero commands are dropped, 1..LANE1_MAX go to add/sub, the rest to shift.
  function automatic lane_e cmd_class(input logic [31:0] cmd);
    if (cmd == 32'd0) begin
      return LANE_NONE;
    end else if (cmd <= 32'(LANE1_MAX)) begin
      return LANE_ALU1;
    end else begin
      return LANE_ALU2;
    end
  endfunction

endpackage

// File: rtl/prio_arbiter_rr_if.sv
// Bundle of requester-side and lane-side signals of prio_arbiter_rr.
// slave = arbiter view, master = requesters/consumers view.
interface prio_arbiter_rr_if #(
  parameter int NUM_PORTS = 4,
  parameter int CMD_W     = prio_pkg::CMD_W_DEF
);
  localparam int ID_W = $clog2(NUM_PORTS);

  // Every vld/rdy pair: a transfer happens on a rising edge where both are
  // high; while vld is high and rdy low the payload (cmd/id) holds stable.
  logic [NUM_PORTS-1:0]       req_vld;
  logic [NUM_PORTS*CMD_W-1:0] req_cmd;
  logic [NUM_PORTS-1:0]       req_rdy;
  logic [NUM_PORTS-1:0]       port_mask;

  logic                       alu1_vld;
  logic [CMD_W-1:0]           alu1_cmd;
  logic [ID_W-1:0]            alu1_id;
  logic                       alu1_rdy;

  logic                       alu2_vld;
  logic [CMD_W-1:0]           alu2_cmd;
  logic [ID_W-1:0]            alu2_id;
  logic                       alu2_rdy;

  logic [7:0]                 drop_cnt;
  logic [ID_W-1:0]            dbg_ptr1;
  logic [ID_W-1:0]            dbg_ptr2;

  modport slave (
    input  req_vld, req_cmd, port_mask, alu1_rdy, alu2_rdy,
    output req_rdy, alu1_vld, alu1_cmd, alu1_id,
    output alu2_vld, alu2_cmd, alu2_id, drop_cnt, dbg_ptr1, dbg_ptr2
  );

  modport master (
    output req_vld, req_cmd, port_mask, alu1_rdy, alu2_rdy,
    input  req_rdy, alu1_vld, alu1_cmd, alu1_id,
    input  alu2_vld, alu2_cmd, alu2_id, drop_cnt, dbg_ptr1, dbg_ptr2
  );

endinterface

// File: rtl/prio_arbiter_rr_pick.sv
// Combinational circular first-one search starting at ptr (rr_en=1)
// or at index 0 (rr_en=0).
module prio_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    cand,
  input  logic [ID_W-1:0] ptr,
  input  logic            rr_en,
  output logic            found,
  output logic [ID_W-1:0] winner
);

  int start;
  int idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    start  = rr_en ? int'(ptr) : 0;
    for (int i = 0; i < N; i++) begin
      idx = (start + i) % N;
      if (!found && cand[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/prio_arbiter_rr.sv
// Per-port one-entry holding slots feeding two independent dispatch lanes
// (add/sub and shift), each with its own output register and RR pointer.
module prio_arbiter_rr import prio_pkg::*; #(
  parameter int NUM_PORTS = 4,
  parameter int CMD_W     = CMD_W_DEF,
  parameter int RR_MODE   = 1
) (
  input logic              c_clk,
  input logic              reset_n,
  prio_arbiter_rr_if.slave bus
);

  localparam int   ID_W  = $clog2(NUM_PORTS);
  localparam logic RR_EN = (RR_MODE != 0);

  logic [NUM_PORTS-1:0] pend_q, rdy_q, pend_nxt;
  logic [CMD_W-1:0]     slot_cmd_q [NUM_PORTS];
  logic [CMD_W-1:0]     in_cmd     [NUM_PORTS];
  lane_e                slot_lane  [NUM_PORTS];
  logic [NUM_PORTS-1:0] acc, keep, drop, cand1, cand2, clr1, clr2;

  logic                 vld1_q, vld2_q;
  logic [CMD_W-1:0]     cmd1_q, cmd2_q;
  logic [ID_W-1:0]      id1_q, id2_q, ptr1_q, ptr2_q;
  logic                 found1, found2, load1, load2;
  logic [ID_W-1:0]      win1, win2;

  logic [7:0]           drop_q, drop_nxt;
  logic [4:0]           n_drop;
  logic [8:0]           drop_sum;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign in_cmd[p]    = bus.req_cmd[p*CMD_W +: CMD_W];
    assign slot_lane[p] = cmd_class(32'(slot_cmd_q[p]));
    assign acc[p]       = bus.req_vld[p] & rdy_q[p];
    assign keep[p]      = acc[p] & (in_cmd[p] != '0);
    assign drop[p]      = acc[p] & (in_cmd[p] == '0);
    // Masked slots are simply not candidates; they keep their command.
    assign cand1[p]     = pend_q[p] & bus.port_mask[p] & (slot_lane[p] == LANE_ALU1);
    assign cand2[p]     = pend_q[p] & bus.port_mask[p] & (slot_lane[p] == LANE_ALU2);
  end

  prio_rr_pick #(.N(NUM_PORTS), .ID_W(ID_W)) u_pick1 (
    .cand(cand1), .ptr(ptr1_q), .rr_en(RR_EN), .found(found1), .winner(win1)
  );

  prio_rr_pick #(.N(NUM_PORTS), .ID_W(ID_W)) u_pick2 (
    .cand(cand2), .ptr(ptr2_q), .rr_en(RR_EN), .found(found2), .winner(win2)
  );

  assign load1 = found1 & (~vld1_q | bus.alu1_rdy);
  assign load2 = found2 & (~vld2_q | bus.alu2_rdy);
  assign clr1  = load1 ? (NUM_PORTS'(1) << win1) : '0;
  assign clr2  = load2 ? (NUM_PORTS'(1) << win2) : '0;

  // An accepting slot is empty, so it can never be the one being cleared.
  assign pend_nxt = (pend_q & ~clr1 & ~clr2) | keep;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      n_drop = n_drop + 5'(drop[i]);
    end
    drop_sum = {1'b0, drop_q} + 9'(n_drop);
    drop_nxt = (drop_sum > 9'd255) ? 8'hff : drop_sum[7:0];
  end

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] w);
    return (w == ID_W'(NUM_PORTS - 1)) ? '0 : ID_W'(w + ID_W'(1));
  endfunction

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      rdy_q  <= '1;
      for (int p = 0; p < NUM_PORTS; p++) slot_cmd_q[p] <= '0;
      drop_q <= '0;
      vld1_q <= 1'b0;
      cmd1_q <= '0;
      id1_q  <= '0;
      ptr1_q <= '0;
      vld2_q <= 1'b0;
      cmd2_q <= '0;
      id2_q  <= '0;
      ptr2_q <= '0;
    end else begin
      pend_q <= pend_nxt;
      rdy_q  <= ~pend_nxt;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (keep[p]) slot_cmd_q[p] <= in_cmd[p];
      end
      drop_q <= drop_nxt;

      if (load1) begin
        vld1_q <= 1'b1;
        cmd1_q <= slot_cmd_q[win1];
        id1_q  <= win1;
        ptr1_q <= next_ptr(win1);
      end else if (bus.alu1_rdy) begin
        vld1_q <= 1'b0;
      end

      if (load2) begin
        vld2_q <= 1'b1;
        cmd2_q <= slot_cmd_q[win2];
        id2_q  <= win2;
        ptr2_q <= next_ptr(win2);
      end else if (bus.alu2_rdy) begin
        vld2_q <= 1'b0;
      end
    end
  end

  assign bus.req_rdy  = rdy_q;
  assign bus.alu1_vld = vld1_q;
  assign bus.alu1_cmd = cmd1_q;
  assign bus.alu1_id  = id1_q;
  assign bus.alu2_vld = vld2_q;
  assign bus.alu2_cmd = cmd2_q;
  assign bus.alu2_id  = id2_q;
  assign bus.drop_cnt = drop_q;
  assign bus.dbg_ptr1 = ptr1_q;
  assign bus.dbg_ptr2 = ptr2_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Directed bench for prio_arbiter_rr: round-robin and fixed-priority
// instances, lane scoreboards popped on every observed transfer.
module tb_prio_arbiter_rr;
  import prio_pkg::*;

  localparam int NP = 4;
  localparam int CW = 4;
  localparam int IW = 2;

  logic c_clk   = 1'b0;
  logic reset_n = 1'b0;

  always #5 c_clk = ~c_clk;

  prio_arbiter_rr_if #(.NUM_PORTS(NP), .CMD_W(CW)) rr_if ();
  prio_arbiter_rr_if #(.NUM_PORTS(NP), .CMD_W(CW)) fx_if ();

  prio_arbiter_rr #(.NUM_PORTS(NP), .CMD_W(CW), .RR_MODE(1)) u_rr (
    .c_clk(c_clk), .reset_n(reset_n), .bus(rr_if.slave)
  );

  prio_arbiter_rr #(.NUM_PORTS(NP), .CMD_W(CW), .RR_MODE(0)) u_fx (
    .c_clk(c_clk), .reset_n(reset_n), .bus(fx_if.slave)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic       mon_en = 1'b0;
  logic [IW+CW-1:0] exp1_q[$];
  logic [IW+CW-1:0] exp2_q[$];
  logic [IW+CW-1:0] fx1_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  function automatic logic [IW+CW-1:0] ent(input int id, input int cmd);
    return {IW'(id), CW'(cmd)};
  endfunction

  function automatic logic [NP*CW-1:0] pack4(input int c3, input int c2, input int c1, input int c0);
    return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endfunction

  // Inputs change only at posedge+1, so at negedge vld&rdy means a transfer
  // on the coming edge.
  always @(negedge c_clk) begin
    if (mon_en && reset_n) begin
      if (rr_if.alu1_vld && rr_if.alu1_rdy) begin
        chk("lane1_q_nonempty", 32'(exp1_q.size() != 0), 32'd1);
        if (exp1_q.size() != 0) chk("lane1_xfer", 32'({rr_if.alu1_id, rr_if.alu1_cmd}), 32'(exp1_q.pop_front()));
      end
      if (rr_if.alu2_vld && rr_if.alu2_rdy) begin
        chk("lane2_q_nonempty", 32'(exp2_q.size() != 0), 32'd1);
        if (exp2_q.size() != 0) chk("lane2_xfer", 32'({rr_if.alu2_id, rr_if.alu2_cmd}), 32'(exp2_q.pop_front()));
      end
      if (fx_if.alu1_vld && fx_if.alu1_rdy) begin
        chk("fx_lane1_q_nonempty", 32'(fx1_q.size() != 0), 32'd1);
        if (fx1_q.size() != 0) chk("fx_lane1_xfer", 32'({fx_if.alu1_id, fx_if.alu1_cmd}), 32'(fx1_q.pop_front()));
      end
    end
  end

  initial begin
    rr_if.req_vld = '0; rr_if.req_cmd = '0; rr_if.port_mask = '1;
    rr_if.alu1_rdy = 1'b0; rr_if.alu2_rdy = 1'b0;
    fx_if.req_vld = '0; fx_if.req_cmd = '0; fx_if.port_mask = '1;
    fx_if.alu1_rdy = 1'b0; fx_if.alu2_rdy = 1'b0;

    // Reset state
    step(); step();
    chk("rst_req_rdy", 32'(rr_if.req_rdy), 32'hf);
    chk("rst_alu1_vld", 32'(rr_if.alu1_vld), 32'd0);
    chk("rst_alu2_vld", 32'(rr_if.alu2_vld), 32'd0);
    chk("rst_drop_cnt", 32'(rr_if.drop_cnt), 32'd0);
    chk("rst_ptr1", 32'(rr_if.dbg_ptr1), 32'd0);
    chk("rst_ptr2", 32'(rr_if.dbg_ptr2), 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single request, port 2 cmd 1
    rr_if.alu1_rdy = 1'b1;
    rr_if.req_vld  = 4'b0100;
    rr_if.req_cmd  = pack4(0, 1, 0, 0);
    exp1_q.push_back(ent(2, 1));
    step();
    chk("single_req_rdy_busy", 32'(rr_if.req_rdy), 32'hb);
    chk("single_not_yet_vld", 32'(rr_if.alu1_vld), 32'd0);
    rr_if.req_vld = '0;
    step();
    chk("single_vld", 32'(rr_if.alu1_vld), 32'd1);
    chk("single_cmd", 32'(rr_if.alu1_cmd), 32'd1);
    chk("single_id", 32'(rr_if.alu1_id), 32'd2);
    chk("single_req_rdy_back", 32'(rr_if.req_rdy), 32'hf);
    chk("single_ptr1", 32'(rr_if.dbg_ptr1), 32'd3);
    step();
    chk("single_vld_drop", 32'(rr_if.alu1_vld), 32'd0);

    // Round-robin, all ports cmd 5 on lane 2
    rr_if.alu2_rdy = 1'b1;
    rr_if.req_vld  = 4'hf;
    rr_if.req_cmd  = pack4(5, 5, 5, 5);
    for (int i = 0; i < NP; i++) exp2_q.push_back(ent(i, 5));
    step();
    chk("rr_all_busy", 32'(rr_if.req_rdy), 32'h0);
    rr_if.req_vld = '0;
    for (int i = 0; i < NP; i++) begin
      step();
      chk("rr_vld", 32'(rr_if.alu2_vld), 32'd1);
      chk("rr_id", 32'(rr_if.alu2_id), 32'(i));
      chk("rr_ptr2", 32'(rr_if.dbg_ptr2), 32'((i + 1) % NP));
    end
    step();
    chk("rr_vld_drop", 32'(rr_if.alu2_vld), 32'd0);
    chk("rr_req_rdy", 32'(rr_if.req_rdy), 32'hf);

    // Mixed lanes and a drop in the same cycle
    rr_if.req_vld = 4'b0111;
    rr_if.req_cmd = pack4(0, 0, 8, 2);
    exp1_q.push_back(ent(0, 2));
    exp2_q.push_back(ent(1, 8));
    step();
    chk("mix_drop_cnt", 32'(rr_if.drop_cnt), 32'd1);
    chk("mix_req_rdy", 32'(rr_if.req_rdy), 32'hc);
    rr_if.req_vld = '0;
    step();
    chk("mix_alu1_vld", 32'(rr_if.alu1_vld), 32'd1);
    chk("mix_alu2_vld", 32'(rr_if.alu2_vld), 32'd1);
    chk("mix_alu1_id", 32'(rr_if.alu1_id), 32'd0);
    chk("mix_alu2_id", 32'(rr_if.alu2_id), 32'd1);
    step();
    chk("mix_alu1_idle", 32'(rr_if.alu1_vld), 32'd0);
    chk("mix_alu2_idle", 32'(rr_if.alu2_vld), 32'd0);

    // Backpressure on lane 1 with a competitor arriving during the stall
    rr_if.alu1_rdy = 1'b0;
    rr_if.req_vld  = 4'b0001;
    rr_if.req_cmd  = pack4(0, 0, 0, 3);
    exp1_q.push_back(ent(0, 3));
    step();
    rr_if.req_vld = 4'b0010;
    rr_if.req_cmd = pack4(0, 0, 1, 0);
    exp1_q.push_back(ent(1, 1));
    step();
    rr_if.req_vld = '0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld", 32'(rr_if.alu1_vld), 32'd1);
      chk("stall_cmd", 32'(rr_if.alu1_cmd), 32'd3);
      chk("stall_id", 32'(rr_if.alu1_id), 32'd0);
      chk("stall_p1_pending", 32'(rr_if.req_rdy), 32'hd);
      step();
    end
    rr_if.alu1_rdy = 1'b1;
    step();
    chk("stall_next_vld", 32'(rr_if.alu1_vld), 32'd1);
    chk("stall_next_id", 32'(rr_if.alu1_id), 32'd1);
    chk("stall_next_cmd", 32'(rr_if.alu1_cmd), 32'd1);
    step();
    chk("stall_done", 32'(rr_if.alu1_vld), 32'd0);

    // Fixed priority: advance past port 2, then ports 1 and 3 compete
    fx_if.alu1_rdy = 1'b1;
    fx_if.req_vld  = 4'b0100;
    fx_if.req_cmd  = pack4(0, 2, 0, 0);
    fx1_q.push_back(ent(2, 2));
    step();
    fx_if.req_vld = 4'b1010;
    fx_if.req_cmd = pack4(2, 0, 2, 0);
    fx1_q.push_back(ent(1, 2));
    fx1_q.push_back(ent(3, 2));
    step();
    fx_if.req_vld = '0;
    chk("fx_first_id", 32'(fx_if.alu1_id), 32'd2);
    step();
    chk("fx_second_id", 32'(fx_if.alu1_id), 32'd1);
    step();
    chk("fx_third_id", 32'(fx_if.alu1_id), 32'd3);
    step();
    chk("fx_idle", 32'(fx_if.alu1_vld), 32'd0);

    // Mask holds port 1, lane 1 stalled, then reset mid-operation
    rr_if.port_mask = 4'b1101;
    rr_if.alu1_rdy  = 1'b0;
    rr_if.alu2_rdy  = 1'b1;
    rr_if.req_vld   = 4'b0011;
    rr_if.req_cmd   = pack4(0, 0, 6, 2);
    step();
    rr_if.req_vld = '0;
    step();
    chk("mask_alu1_held", 32'(rr_if.alu1_vld), 32'd1);
    chk("mask_alu2_blocked", 32'(rr_if.alu2_vld), 32'd0);
    chk("mask_req_rdy", 32'(rr_if.req_rdy), 32'hd);
    step();
    chk("mask_still_blocked", 32'(rr_if.alu2_vld), 32'd0);
    chk("mask_still_pending", 32'(rr_if.req_rdy), 32'hd);
    reset_n = 1'b0;
    #1;
    chk("midrst_alu1_vld", 32'(rr_if.alu1_vld), 32'd0);
    chk("midrst_alu2_vld", 32'(rr_if.alu2_vld), 32'd0);
    chk("midrst_req_rdy", 32'(rr_if.req_rdy), 32'hf);
    chk("midrst_drop_cnt", 32'(rr_if.drop_cnt), 32'd0);
    chk("midrst_ptr1", 32'(rr_if.dbg_ptr1), 32'd0);
    rr_if.port_mask = '1;
    step();
    reset_n = 1'b1;
    step();
    chk("postrst_no_ghost", 32'(rr_if.alu2_vld), 32'd0);

    // Drop counter saturation, four drops per cycle from the first edge
    rr_if.req_vld = 4'hf;
    rr_if.req_cmd = pack4(0, 0, 0, 0);
    step();
    chk("drop_first_edge", 32'(rr_if.drop_cnt), 32'd4);
    repeat (62) step();
    chk("drop_252", 32'(rr_if.drop_cnt), 32'd252);
    chk("drop_no_occupy", 32'(rr_if.req_rdy), 32'hf);
    step();
    chk("drop_sat", 32'(rr_if.drop_cnt), 32'd255);
    step();
    chk("drop_sat_hold", 32'(rr_if.drop_cnt), 32'd255);
    rr_if.req_vld = '0;
    step();

    chk("exp1_q_drained", 32'(exp1_q.size()), 32'd0);
    chk("exp2_q_drained", 32'(exp2_q.size()), 32'd0);
    chk("fx1_q_drained", 32'(fx1_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
